sprite_layer_scheduler: RTL and testbench
=========================================

// Module: sprite_layer_scheduler
// PURPOSE
//  Time-shares one sprite-index ROM port and one 16-entry palette between NUM_LAYERS sprite layers.
//  Per requested pixel it walks the layers covering (DrawX,DrawY) in priority order and returns the first opaque colour.
//  Opaque means a palette index != KEY_INDEX; if no layer is opaque it returns BG_RGB.
//  Sits between the VGA pixel request logic (2 clocks per pixel) and the sprite ROM/palette pair.
// PARAMETERS
//  NUM_LAYERS  4       sprite layers; layer 0 = highest priority
//  SPRITE_W    32      sprite width, pixels (power of 2)
//  SPRITE_H    32      sprite height, pixels
//  ADDR_W      10      ROM address width = $clog2(SPRITE_W*SPRITE_H)
//  KEY_INDEX   4'd0    transparent palette index (chroma key, entry 0 = 12'hE00)
//  BG_RGB      12'h000 colour when no opaque layer hits
// PORTS
//  Clk        in   1             system clock
//  Reset      in   1             synchronous, active-high
//  pix_valid  in   1             pixel request
//  pix_ready  out  1             scheduler idle; request accepted when pix_valid&&pix_ready
//  DrawX      in   10            pixel column, sampled on accept
//  DrawY      in   10            pixel row, sampled on accept
//  layer_en   in   NUM_LAYERS    per-layer enable, sampled on accept
//  layer_x    in   NUM_LAYERS*10 packed top-left X per layer (layer i at [10*i+:10])
//  layer_y    in   NUM_LAYERS*10 packed top-left Y per layer
//  rom_rd     out  1             ROM read strobe
//  rom_sel    out  $clog2(NUM_LAYERS) layer whose ROM is read
//  rom_addr   out  ADDR_W        ROM address; data returns next cycle
//  rom_index  in   4             palette index from ROM, valid cycle after rom_rd
//  pal_index  out  4             index to shared palette (combinational lookup)
//  pal_red/pal_green/pal_blue  in 4 each  palette output
//  red/green/blue  out 4 each    registered pixel colour
//  rgb_valid  out  1             one-cycle pulse: red/green/blue valid for accepted pixel
// BEHAVIOUR
//  Reset (sync): state IDLE, rgb_valid=0, rom_rd=0, rom_sel=0, rom_addr=0, pal_index=0, RGB=0.
//  pix_ready=0 while Reset high, else (state==IDLE).
//  Reset mid-pixel: pixel discarded, no rgb_valid.
//  Accept (IDLE, cycle T): latch DrawX/DrawY/positions, build cand mask; bit i set iff
//    layer_en[i] && DrawX>=lx && DrawX<lx+SPRITE_W && DrawY>=ly && DrawY<ly+SPRITE_H.
//    Compare in 11 bits: lx+SPRITE_W must not wrap at X=1023.
//  FSM IDLE->FETCH if cand!=0, else IDLE->DONE with BG_RGB latched.
//  FETCH (1 cycle): pick lowest set bit i of cand, clear it.
//    rom_rd=1, rom_sel=i, rom_addr=(DrawY-ly)*SPRITE_W+(DrawX-lx) (ADDR_W bits). -> CHECK.
//  CHECK: pal_index=rom_index.
//    rom_index!=KEY_INDEX: latch {pal_red,pal_green,pal_blue} -> DONE.
//    key && cand!=0: -> FETCH.
//    key && cand==0: latch BG_RGB -> DONE.
//  DONE: rgb_valid=1 for exactly this cycle -> IDLE.
//  red/green/blue: updated only when entering DONE; held otherwise.
//  Latency (accept edge T to rgb_valid):
//    no hit                              T+1
//    first layer opaque                  T+3
//    each extra transparent layer        +2
//    worst case (all NUM_LAYERS covering) T+1+2*NUM_LAYERS
//  rom_rd only in FETCH; rom_sel/rom_addr hold last value otherwise; pal_index=0 outside CHECK.
//  Layer input changes after accept have no effect on the in-flight pixel.
//  pix_valid while busy: ignored, requester must hold it.
// STRUCTURE
//  Package sprite_pkg: sched_state_t enum {IDLE,FETCH,CHECK,DONE}; COORD_W=10; RGB_W=12; KEY_INDEX default.
//  Sub-module layer_priority_enc: NUM_LAYERS mask -> lowest set index + any flag (combinational).
//  Remainder is one FSM with datapath registers in this file.
// TESTING
//  1 No layers enabled, request (100,100) -> rgb_valid at T+1, RGB=000, rom_rd never asserted.
//  2 Layer0 at (96,64), ROM index 5, request (100,70)
//      -> rom_addr=6*32+4=196, rom_sel=0 at T+1; pal_index=5 at T+2; rgb_valid at T+3, RGB=084.
//  3 Layers 0 and 2 cover; layer0 returns 0 (key), layer2 returns 9
//      -> rom_sel 0 then 2, rgb_valid at T+5, RGB=DB9.
//  4 All 4 layers cover, all return key -> 4 rom_rd pulses, rgb_valid at T+9, RGB=BG_RGB, pix_ready low T+1..T+9.
//  5 Edge: layer at x=1000, request DrawX=1023 -> covered (no wrap); DrawX=(lx+32) -> not covered.
//  6 Reset asserted during CHECK -> next cycle IDLE, RGB=000, no rgb_valid; new request served normally.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite layer scheduler.
//   sched_state_t      : scheduler FSM states
//   COORD_W / RGB_W    : screen coordinate width and packed 4:4:4 colour width
//   PAL_W              : palette index width
//   DEFAULT_KEY_INDEX  : transparent (chroma key) palette index
//   DEFAULT_BG_RGB     : colour returned when no layer is opaque
//   sel_width()        : width of a layer-select field for n layers (min 1)
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 12;
    localparam int PAL_W   = 4;

    localparam logic [PAL_W-1:0] DEFAULT_KEY_INDEX = 4'd0;
    localparam logic [RGB_W-1:0] DEFAULT_BG_RGB    = 12'h000;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Lowest-set-bit priority encoder over the layer candidate mask.
//   mask : one bit per layer, bit 0 = highest priority
//   idx  : index of the lowest set bit (0 when mask is empty)
//   any  : mask has at least one bit set
module layer_priority_enc
    import sprite_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_layer_scheduler.sv
// Time-shares one sprite-index ROM port and one palette between NUM_LAYERS
// sprite layers. For each accepted pixel it walks the layers covering
// (DrawX, DrawY) in priority order (layer 0 first) and returns the colour of
// the first layer whose palette index is not the chroma key, else BG_RGB.
//
// Ports
//   Clk, Reset           : clock, synchronous active-high reset
//   pix_valid/pix_ready  : pixel request handshake
//   DrawX, DrawY         : requested pixel, sampled on accept
//   layer_en/x/y         : per-layer enable and packed top-left corners
//                          (layer i at [10*i +: 10]), sampled on accept
//   rom_rd/sel/addr      : ROM read request; data returns the next cycle
//   rom_index            : palette index from the ROM
//   pal_index            : index into the shared palette (combinational lookup)
//   pal_red/green/blue   : palette output
//   red/green/blue       : registered pixel colour
//   rgb_valid            : one-cycle pulse, colour valid for accepted pixel
//   dbg_state            : current FSM state
//
// Handshake: a request transfers on a rising edge where pix_valid && pix_ready.
// pix_ready is high only in IDLE and never during Reset; a requester seeing
// pix_ready low must keep pix_valid (and its data) asserted until accepted.
module sprite_layer_scheduler
    import sprite_pkg::*;
#(
    parameter int               NUM_LAYERS = 4,
    parameter int               SPRITE_W   = 32,
    parameter int               SPRITE_H   = 32,
    parameter int               ADDR_W     = 10,
    parameter logic [PAL_W-1:0] KEY_INDEX  = DEFAULT_KEY_INDEX,
    parameter logic [RGB_W-1:0] BG_RGB     = DEFAULT_BG_RGB
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic [NUM_LAYERS-1:0]            layer_en,
    input  logic [NUM_LAYERS*COORD_W-1:0]    layer_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]    layer_y,
    output logic                             rom_rd,
    output logic [sel_width(NUM_LAYERS)-1:0] rom_sel,
    output logic [ADDR_W-1:0]                rom_addr,
    input  logic [PAL_W-1:0]                 rom_index,
    output logic [PAL_W-1:0]                 pal_index,
    input  logic [3:0]                       pal_red,
    input  logic [3:0]                       pal_green,
    input  logic [3:0]                       pal_blue,
    output logic [3:0]                       red,
    output logic [3:0]                       green,
    output logic [3:0]                       blue,
    output logic                             rgb_valid,
    output sched_state_t                     dbg_state
);

    localparam int SEL_W = sel_width(NUM_LAYERS);
    localparam int EXT_W = COORD_W + 1;

    sched_state_t                  state;
    logic [NUM_LAYERS-1:0]         cand_r;
    logic [COORD_W-1:0]            px, py;
    logic [NUM_LAYERS*COORD_W-1:0] lx_r, ly_r;

    logic [NUM_LAYERS-1:0]         cand_new;
    logic [NUM_LAYERS-1:0]         enc_mask;
    logic [SEL_W-1:0]              pick;
    logic                          pick_any;
    logic [NUM_LAYERS-1:0]         pick_onehot;

    logic [COORD_W-1:0]            cur_x, cur_y;
    logic [NUM_LAYERS*COORD_W-1:0] cur_lx, cur_ly;
    logic [COORD_W-1:0]            pick_lx, pick_ly;
    logic [COORD_W-1:0]            dx, dy;
    logic [ADDR_W-1:0]             fetch_addr;

    logic [EXT_W-1:0]              x11, y11, lx11, ly11;

    assign pix_ready = !Reset && (state == IDLE);
    assign dbg_state = state;

    // Coverage test for the incoming request. Done in 11 bits so that a
    // sprite whose right/bottom edge lies past 1023 does not wrap to 0.
    always_comb begin
        cand_new = '0;
        x11      = {1'b0, DrawX};
        y11      = {1'b0, DrawY};
        lx11     = '0;
        ly11     = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            lx11 = {1'b0, layer_x[i*COORD_W +: COORD_W]};
            ly11 = {1'b0, layer_y[i*COORD_W +: COORD_W]};
            cand_new[i] = layer_en[i]
                       && (x11 >= lx11) && (x11 < lx11 + EXT_W'(SPRITE_W))
                       && (y11 >= ly11) && (y11 < ly11 + EXT_W'(SPRITE_H));
        end
    end

    // In IDLE the first fetch is issued straight from the live request, so
    // the encoder and address path look at the inputs; afterwards they use
    // the latched copies so later input changes cannot disturb the pixel.
    assign enc_mask = (state == IDLE) ? cand_new : cand_r;
    assign cur_x    = (state == IDLE) ? DrawX    : px;
    assign cur_y    = (state == IDLE) ? DrawY    : py;
    assign cur_lx   = (state == IDLE) ? layer_x  : lx_r;
    assign cur_ly   = (state == IDLE) ? layer_y  : ly_r;

    layer_priority_enc #(
        .N     (NUM_LAYERS),
        .IDX_W (SEL_W)
    ) u_enc (
        .mask (enc_mask),
        .idx  (pick),
        .any  (pick_any)
    );

    assign pick_onehot = NUM_LAYERS'(1) << pick;
    assign pick_lx     = cur_lx[int'(pick)*COORD_W +: COORD_W];
    assign pick_ly     = cur_ly[int'(pick)*COORD_W +: COORD_W];
    assign dx          = cur_x - pick_lx;
    assign dy          = cur_y - pick_ly;
    assign fetch_addr  = ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx);

    // The palette is a combinational lookup on the ROM index returned
    // during CHECK; outside CHECK the index is parked at 0.
    always_comb begin
        pal_index = '0;
        if (state == CHECK) begin
            pal_index = rom_index;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cand_r    <= '0;
            px        <= '0;
            py        <= '0;
            lx_r      <= '0;
            ly_r      <= '0;
            rom_rd    <= 1'b0;
            rom_sel   <= '0;
            rom_addr  <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rom_rd    <= 1'b0;
            rgb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pix_valid) begin
                        px   <= DrawX;
                        py   <= DrawY;
                        lx_r <= layer_x;
                        ly_r <= layer_y;
                        if (pick_any) begin
                            state    <= FETCH;
                            rom_rd   <= 1'b1;
                            rom_sel  <= pick;
                            rom_addr <= fetch_addr;
                            cand_r   <= cand_new & ~pick_onehot;
                        end else begin
                            state               <= DONE;
                            cand_r              <= '0;
                            {red, green, blue}  <= BG_RGB;
                            rgb_valid           <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (rom_index != KEY_INDEX) begin
                        state              <= DONE;
                        {red, green, blue} <= {pal_red, pal_green, pal_blue};
                        rgb_valid          <= 1'b1;
                    end else if (pick_any) begin
                        // Transparent here; try the next covering layer.
                        state    <= FETCH;
                        rom_rd   <= 1'b1;
                        rom_sel  <= pick;
                        rom_addr <= fetch_addr;
                        cand_r   <= cand_r & ~pick_onehot;
                    end else begin
                        state              <= DONE;
                        {red, green, blue} <= BG_RGB;
                        rgb_valid          <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Directed bench for sprite_layer_scheduler: a table of pixel requests with
// hand-computed latency, colour, fetch order and first ROM address, plus
// hand-written sequences for the detailed fetch/check timing and for a
// reset arriving while a pixel is in flight.
module tb_sprite_layer_scheduler;
    import sprite_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic Reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              pix_valid, pix_ready;
    logic [9:0]        DrawX, DrawY;
    logic [3:0]        layer_en;
    logic [3:0][9:0]   layer_x, layer_y;
    logic              rom_rd;
    logic [1:0]        rom_sel;
    logic [9:0]        rom_addr;
    logic [3:0]        rom_index;
    logic [3:0]        pal_index;
    logic [3:0]        pal_red, pal_green, pal_blue;
    logic [3:0]        red, green, blue;
    logic              rgb_valid;
    sched_state_t      dbg_state;

    sprite_layer_scheduler dut (
        .Clk       (clk),
        .Reset     (Reset),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .layer_en  (layer_en),
        .layer_x   (layer_x),
        .layer_y   (layer_y),
        .rom_rd    (rom_rd),
        .rom_sel   (rom_sel),
        .rom_addr  (rom_addr),
        .rom_index (rom_index),
        .pal_index (pal_index),
        .pal_red   (pal_red),
        .pal_green (pal_green),
        .pal_blue  (pal_blue),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .rgb_valid (rgb_valid),
        .dbg_state (dbg_state)
    );

    // ---------------- ROM and palette models ----------------
    // Each layer's sprite returns a single palette index everywhere.
    logic [3:0][3:0] rom_tbl;
    always @(posedge clk) begin
        if (rom_rd) rom_index <= rom_tbl[rom_sel];
    end

    function automatic logic [11:0] pal_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 12'hE00;
            4'd3:    return 12'h123;
            4'd5:    return 12'h084;
            4'd7:    return 12'hF0F;
            4'd9:    return 12'hDB9;
            default: return {i, i, i};
        endcase
    endfunction
    assign {pal_red, pal_green, pal_blue} = pal_lut(pal_index);

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0]      x;
        logic [9:0]      y;
        logic [3:0]      en;
        logic [3:0][9:0] lx;
        logic [3:0][9:0] ly;
        logic [3:0][3:0] idx;
        int              lat;
        logic [11:0]     rgb;
        int              nrd;
        logic [7:0]      sels;   // rom_sel of fetch n at [2n +: 2]
        logic [9:0]      addr0;  // address of the first fetch
    } vec_t;

    function automatic logic [3:0][9:0] pos4(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][9:0] p;
        p[0] = 10'(a0); p[1] = 10'(a1); p[2] = 10'(a2); p[3] = 10'(a3);
        return p;
    endfunction

    function automatic logic [3:0][3:0] idx4(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][3:0] p;
        p[0] = 4'(a0); p[1] = 4'(a1); p[2] = 4'(a2); p[3] = 4'(a3);
        return p;
    endfunction

    vec_t vecs[11];

    // ---------------- driver ----------------
    task automatic do_pixel(input int n, input vec_t v);
        int          lat, nrd, busy_bad;
        logic [7:0]  sels;
        logic [9:0]  addr0;
        logic [11:0] got;
        bit          done;
        @(negedge clk);
        DrawX     = v.x;
        DrawY     = v.y;
        layer_en  = v.en;
        layer_x   = v.lx;
        layer_y   = v.ly;
        rom_tbl   = v.idx;
        pix_valid = 1'b1;
        chk($sformatf("v%0d ready_before", n), 32'(pix_ready), 32'd1);
        exp_q.push_back(v.rgb);
        lat = 0; nrd = 0; busy_bad = 0; sels = '0; addr0 = '0; done = 0; got = '0;
        for (int k = 1; k <= 24 && !done; k++) begin
            @(negedge clk);
            // Scramble everything after accept; the in-flight pixel must not care.
            pix_valid = 1'b0;
            DrawX     = 10'($urandom_range(0, 1023));
            DrawY     = 10'($urandom_range(0, 1023));
            layer_en  = 4'($urandom_range(0, 15));
            layer_x   = 40'({$urandom(), $urandom()});
            layer_y   = 40'({$urandom(), $urandom()});
            if (rom_rd) begin
                if (nrd == 0) addr0 = rom_addr;
                if (nrd < 4) sels[2*nrd +: 2] = rom_sel;
                nrd++;
            end
            if (pix_ready) busy_bad++;
            if (rgb_valid) begin
                lat  = k;
                done = 1;
                got  = {red, green, blue};
                chk($sformatf("v%0d rgb", n), 32'(got), 32'(exp_q.pop_front()));
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL v%0d timeout: got no rgb_valid expected one at %0d", n, v.lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        chk($sformatf("v%0d latency", n), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d rom_rd_count", n), 32'(nrd), 32'(v.nrd));
        chk($sformatf("v%0d sel_order", n), 32'(sels), 32'(v.sels));
        if (v.nrd > 0) chk($sformatf("v%0d first_addr", n), 32'(addr0), 32'(v.addr0));
        chk($sformatf("v%0d busy_ready", n), 32'(busy_bad), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d ready_after", n), 32'(pix_ready), 32'd1);
        chk($sformatf("v%0d valid_pulse", n), 32'(rgb_valid), 32'd0);
        chk($sformatf("v%0d rgb_hold", n), 32'({red, green, blue}), 32'(v.rgb));
    endtask

    // ---------------- main test ----------------
    initial begin
        int vcount;
        Reset = 1'b1; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
        layer_en = '0; layer_x = '0; layer_y = '0; rom_tbl = '0; rom_index = '0;

        //      x     y    en       lx                      ly                  idx            lat rgb     nrd sels  addr0
        vecs[0]  = '{10'd100, 10'd100, 4'b0000, pos4(0,0,0,0),       pos4(0,0,0,0),     idx4(0,0,0,0), 1, 12'h000, 0, 8'h00, 10'd0};
        vecs[1]  = '{10'd100, 10'd70,  4'b0001, pos4(96,0,0,0),      pos4(64,0,0,0),    idx4(5,0,0,0), 3, 12'h084, 1, 8'h00, 10'd196};
        vecs[2]  = '{10'd100, 10'd70,  4'b0101, pos4(96,0,90,0),     pos4(64,0,60,0),   idx4(0,0,9,0), 5, 12'hDB9, 2, 8'h08, 10'd196};
        vecs[3]  = '{10'd100, 10'd70,  4'b1111, pos4(96,80,90,100),  pos4(64,50,60,70), idx4(0,0,0,0), 9, 12'h000, 4, 8'hE4, 10'd196};
        vecs[4]  = '{10'd1023,10'd20,  4'b0001, pos4(1000,0,0,0),    pos4(10,0,0,0),    idx4(7,0,0,0), 3, 12'hF0F, 1, 8'h00, 10'd343};
        vecs[5]  = '{10'd532, 10'd5,   4'b0001, pos4(500,0,0,0),     pos4(0,0,0,0),     idx4(7,0,0,0), 1, 12'h000, 0, 8'h00, 10'd0};
        vecs[6]  = '{10'd1023,10'd31,  4'b0001, pos4(992,0,0,0),     pos4(0,0,0,0),     idx4(3,0,0,0), 3, 12'h123, 1, 8'h00, 10'd1023};
        vecs[7]  = '{10'd100, 10'd70,  4'b1010, pos4(96,96,0,100),   pos4(64,64,0,70),  idx4(5,0,0,5), 5, 12'h084, 2, 8'h0D, 10'd196};
        vecs[8]  = '{10'd5,   10'd132, 4'b0001, pos4(0,0,0,0),       pos4(100,0,0,0),   idx4(5,0,0,0), 1, 12'h000, 0, 8'h00, 10'd0};
        vecs[9]  = '{10'd100, 10'd70,  4'b0111, pos4(96,80,90,100),  pos4(64,50,60,70), idx4(0,0,9,0), 7, 12'hDB9, 3, 8'h24, 10'd196};
        vecs[10] = '{10'd100, 10'd70,  4'b0001, pos4(101,0,0,0),     pos4(70,0,0,0),    idx4(5,0,0,0), 1, 12'h000, 0, 8'h00, 10'd0};
        vcount = 11;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready_low", 32'(pix_ready), 32'd0);
        chk("rst rgb_valid", 32'(rgb_valid), 32'd0);
        chk("rst rom_rd",    32'(rom_rd),    32'd0);
        chk("rst rom_sel",   32'(rom_sel),   32'd0);
        chk("rst rom_addr",  32'(rom_addr),  32'd0);
        chk("rst pal_index", 32'(pal_index), 32'd0);
        chk("rst rgb",       32'({red, green, blue}), 32'd0);
        chk("rst state",     32'(dbg_state), 32'(IDLE));
        Reset = 1'b0;
        @(negedge clk);
        chk("rst ready_high", 32'(pix_ready), 32'd1);

        // Table-driven pixels.
        for (int i = 0; i < vcount; i++) do_pixel(i, vecs[i]);

        // Detailed timing of a single opaque hit (layer 0 at (96,64), index 5).
        @(negedge clk);
        DrawX = 10'd100; DrawY = 10'd70; layer_en = 4'b0001;
        layer_x = pos4(96,0,0,0); layer_y = pos4(64,0,0,0); rom_tbl = idx4(5,0,0,0);
        pix_valid = 1'b1;
        @(negedge clk);  // T+1: FETCH
        pix_valid = 1'b0;
        chk("t2 rom_rd_t1",    32'(rom_rd),    32'd1);
        chk("t2 rom_sel_t1",   32'(rom_sel),   32'd0);
        chk("t2 rom_addr_t1",  32'(rom_addr),  32'd196);
        chk("t2 pal_idx_t1",   32'(pal_index), 32'd0);
        @(negedge clk);  // T+2: CHECK
        chk("t2 rom_rd_t2",    32'(rom_rd),    32'd0);
        chk("t2 rom_addr_t2",  32'(rom_addr),  32'd196);
        chk("t2 pal_idx_t2",   32'(pal_index), 32'd5);
        chk("t2 valid_t2",     32'(rgb_valid), 32'd0);
        @(negedge clk);  // T+3: DONE
        chk("t2 valid_t3",     32'(rgb_valid), 32'd1);
        chk("t2 rgb_t3",       32'({red, green, blue}), 32'h084);
        chk("t2 pal_idx_t3",   32'(pal_index), 32'd0);

        // Reset while the pixel sits in CHECK.
        @(negedge clk);
        pix_valid = 1'b1;
        @(negedge clk);  // FETCH
        pix_valid = 1'b0;
        @(negedge clk);  // CHECK
        chk("t6 in_check", 32'(dbg_state), 32'(CHECK));
        Reset = 1'b1;
        @(negedge clk);
        chk("t6 state",     32'(dbg_state), 32'(IDLE));
        chk("t6 rgb",       32'({red, green, blue}), 32'd0);
        chk("t6 rgb_valid", 32'(rgb_valid), 32'd0);
        chk("t6 ready_low", 32'(pix_ready), 32'd0);
        Reset = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (rgb_valid) stray++;
            end
            chk("t6 no_stray_valid", 32'(stray), 32'd0);
        end
        do_pixel(100, vecs[2]);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
